// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the iterative multiplier: widths, op/state encodings,
// the zero-register index and a magnitude helper for signed high multiplies.
package mul_seq_unit_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_SMULH = 2'b10,
    OP_RSVD  = 2'b11
  } mulOpT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

  // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_seq_unit.sv
// Radix-2 shift-add multiplier for MUL/UMULH/SMULH: one multiplier bit per
// clock, single-cycle Done pulse with a write-back request unless Rd is XZR.
module mul_seq_unit
  import mul_seq_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic [REG_W-1:0]  Rd,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [REG_W-1:0]  ResultRd,
  output logic              RegWrReq
);

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [PROD_W-1:0] acc, accNext;
  logic [DATA_W-1:0] mcand, mcandNext;
  logic [DATA_W-1:0] mplier, mplierNext;
  logic              neg, negNext;
  mulOpT             opReg, opNext;
  logic [DATA_W-1:0] resultNext;
  logic [REG_W-1:0]  resultRdNext;
  logic              busyNext, doneNext, regWrNext;

  logic [DATA_W:0]   sum;
  logic [PROD_W-1:0] stepAcc;
  logic [PROD_W-1:0] prod;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      opReg    <= OP_MUL;
      Result   <= '0;
      ResultRd <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      RegWrReq <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      acc      <= accNext;
      mcand    <= mcandNext;
      mplier   <= mplierNext;
      neg      <= negNext;
      opReg    <= opNext;
      Result   <= resultNext;
      ResultRd <= resultRdNext;
      Busy     <= busyNext;
      Done     <= doneNext;
      RegWrReq <= regWrNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    accNext      = acc;
    mcandNext    = mcand;
    mplierNext   = mplier;
    negNext      = neg;
    opNext       = opReg;
    resultNext   = Result;
    resultRdNext = ResultRd;
    sum          = '0;
    stepAcc      = acc;
    prod         = '0;

    case (state)
      IDLE: begin
        if (Start) begin
          opNext       = mulOpT'(Op);
          resultRdNext = Rd;
          accNext      = '0;
          cntNext      = '0;
          if (mulOpT'(Op) == OP_SMULH) begin
            mcandNext  = absVal(OpA);
            mplierNext = absVal(OpB);
            negNext    = OpA[DATA_W-1] ^ OpB[DATA_W-1];
          end else begin
            mcandNext  = OpA;
            mplierNext = OpB;
            negNext    = 1'b0;
          end
          stateNext = RUN;
        end
      end
      RUN: begin
        // Add into the upper half with carry, then shift {carry, acc} right.
        sum        = {1'b0, acc[PROD_W-1:DATA_W]} + {1'b0, (mplier[0] ? mcand : '0)};
        stepAcc    = {sum, acc[DATA_W-1:1]};
        accNext    = stepAcc;
        mplierNext = mplier >> 1;
        cntNext    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          prod = (opReg == OP_SMULH && neg) ? (~stepAcc + PROD_W'(1)) : stepAcc;
          resultNext = (opReg == OP_UMULH || opReg == OP_SMULH) ?
                       prod[PROD_W-1:DATA_W] : prod[DATA_W-1:0];
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    busyNext  = (stateNext != IDLE);
    doneNext  = (stateNext == DONE);
    regWrNext = doneNext && (resultRdNext != XZR);
  end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: table of multiplies with hand-computed
// results, plus Start-during-RUN and asynchronous mid-run reset sequences.
module tb_mul_seq_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [63:0] OpA, OpB;
  logic [4:0]  Rd;
  logic        Busy, Done, RegWrReq;
  logic [63:0] Result;
  logic [4:0]  ResultRd;

  int total = 0;
  int passed = 0;

  mul_seq_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Rd(Rd), .Busy(Busy), .Done(Done), .Result(Result), .ResultRd(ResultRd),
    .RegWrReq(RegWrReq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] expRes;
    logic        expWr;
  } vecT;

  vecT vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; that cycle is cycle 0.
  task automatic runVec(input string name, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] expRes, input logic expWr, input int glitch);
    int          doneCyc;
    int          doneCnt;
    logic        busyOk;
    logic [63:0] resAtDone;
    logic        wrAtDone;
    logic [4:0]  rdAtDone;
    doneCyc = -1; doneCnt = 0; busyOk = 1'b1;
    resAtDone = 'x; wrAtDone = 1'bx; rdAtDone = 'x;
    Op = op; OpA = a; OpB = b; Rd = rd; Start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      stepCycle();
      if (c == 1) begin
        Start = 1'b0; OpA = ~a; OpB = b ^ 64'h5A5A_5A5A_0000_0003; Rd = ~rd; Op = ~op;
      end
      if (glitch != 0 && c == glitch) Start = 1'b1;
      if (glitch != 0 && c == glitch + 1) Start = 1'b0;
      if (Busy !== (c <= 65)) busyOk = 1'b0;
      if (Done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) begin
          doneCyc = c; resAtDone = Result; wrAtDone = RegWrReq; rdAtDone = ResultRd;
        end
      end
    end
    check({name, " doneCycle"}, 64'(doneCyc), 64'd65);
    check({name, " donePulses"}, 64'(doneCnt), 64'd1);
    check({name, " busyWindow"}, 64'(busyOk), 64'd1);
    check({name, " result"}, resAtDone, expRes);
    check({name, " regWrReq"}, 64'(wrAtDone), 64'(expWr));
    check({name, " resultRd"}, 64'(rdAtDone), 64'(rd));
    check({name, " resultHold"}, Result, expRes);
  endtask

  initial begin
    logic noActivity;
    vecs[0] = '{"mul3x5",      2'b00, 64'd3, 64'd5, 5'd2, 64'h0000_0000_0000_000F, 1'b1};
    vecs[1] = '{"mulAllOnesX2", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[2] = '{"umulhAllOnesX2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'h0000_0000_0000_0001, 1'b1};
    vecs[3] = '{"smulhNeg1x1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4] = '{"smulhMinxMin", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6, 64'h4000_0000_0000_0000, 1'b1};
    vecs[5] = '{"smulh7xNeg3", 2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6] = '{"mul4x4Xzr",   2'b00, 64'd4, 64'd4, 5'd31, 64'h0000_0000_0000_0010, 1'b0};
    vecs[7] = '{"rsvd5x6",     2'b11, 64'd5, 64'd6, 5'd8, 64'h0000_0000_0000_001E, 1'b1};
    vecs[8] = '{"umulhMax",    2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[9] = '{"smulhMinx1",  2'b10, 64'h8000_0000_0000_0000, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0; Rd = '0;
    #23;
    check("resetBusy", 64'(Busy), 64'd0);
    check("resetDone", 64'(Done), 64'd0);
    check("resetRegWr", 64'(RegWrReq), 64'd0);
    check("resetResult", Result, 64'd0);
    check("resetResultRd", 64'(ResultRd), 64'd0);
    Reset = 1'b0;
    stepCycle();

    for (int i = 0; i < 10; i++)
      runVec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].expRes, vecs[i].expWr, 0);

    // Start pulsed with different operands in cycle 10 must be ignored.
    runVec("startDuringRun", 2'b00, 64'd3, 64'd5, 5'd2, 64'h0000_0000_0000_000F, 1'b1, 10);

    // Asynchronous reset in the middle of cycle 30 of a run.
    Op = 2'b00; OpA = 64'd9; OpB = 64'd9; Rd = 5'd3; Start = 1'b1;
    stepCycle();
    Start = 1'b0;
    for (int c = 2; c <= 30; c++) stepCycle();
    #3 Reset = 1'b1;
    #1;
    check("midResetBusy", 64'(Busy), 64'd0);
    check("midResetDone", 64'(Done), 64'd0);
    check("midResetRegWr", 64'(RegWrReq), 64'd0);
    check("midResetResult", Result, 64'd0);
    check("midResetResultRd", 64'(ResultRd), 64'd0);
    @(posedge Clk);
    #3 Reset = 1'b0;
    stepCycle();
    noActivity = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (Busy !== 1'b0 || Done !== 1'b0 || RegWrReq !== 1'b0) noActivity = 1'b0;
      stepCycle();
    end
    check("abortNoWrite", 64'(noActivity), 64'd1);
    runVec("mul6x7AfterReset", 2'b00, 64'd6, 64'd7, 5'd4, 64'h0000_0000_0000_002A, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Iterative 64-bit integer multiplier for MUL, UMULH and SMULH. It sits between register-file read and write-back.
- Consumes BusA/BusB operand values and the destination register number.
- Produces a 64-bit result plus a one-cycle write request that the write-back mux routes onto BusW/RW/RegWr.
- Radix-2 shift-add, one multiplier bit per clock. The control unit stalls the PC while Busy is high.

Parameters:
- DATA_W, 64, operand/result width; product width is 2*DATA_W.
- CNT_W, 7, iteration counter width; must hold DATA_W.

Ports:
- Clk  input  1  system clock, rising-edge state updates.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- Op  input  2  00 MUL (low 64), 01 UMULH (high 64 unsigned), 10 SMULH (high 64 signed), 11 reserved = MUL.
- OpA  input  DATA_W  multiplicand (from BusA).
- OpB  input  DATA_W  multiplier (from BusB).
- Rd  input  5  destination register number.
- Busy  output  1  high while not IDLE.
- Done  output  1  one-cycle pulse, result valid.
- Result  output  DATA_W  selected product half.
- ResultRd  output  5  latched Rd.
- RegWrReq  output  1  write-back request (Done and ResultRd != 31).

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is asynchronous and active-high.
  - Reset forces state=IDLE, counter=0, accumulator=0.
  - Reset values: Busy=0, Done=0, RegWrReq=0, Result=0, ResultRd=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On Start=1 at a rising edge: latch Op and Rd, load operands, clear the 128-bit accumulator, counter=0, go to RUN.
  - Start=0: stay in IDLE.
- Operand load:
  - MUL/UMULH/reserved: operands taken as-is.
  - SMULH: load |OpA| and |OpB| as unsigned 64-bit magnitudes; latch neg = OpA[63] XOR OpB[63].
  - |-2^63| = 2^63 as unsigned; this is legal.
- RUN (one step per edge):
  - If multiplier LSB=1, add the multiplicand into accumulator bits [127:64] with carry.
  - Shift the {carry, accumulator} right by 1 and shift the multiplier right by 1.
  - counter++.
  - After the 64th step (counter reaches DATA_W), go to DONE.
- Final result (registered on the transition into DONE):
  - SMULH with neg=1: two's-complement negate the 128-bit product.
  - Result = product[63:0] for MUL/reserved, product[127:64] otherwise.
- DONE (exactly one cycle):
  - Done=1; RegWrReq=1 unless ResultRd=31 (XZR writes suppressed; Done still pulses).
  - Unconditionally return to IDLE.
- Latency: Start high in cycle 0 → Done high in cycle 65. Busy high in cycles 1..65.
- Result and ResultRd hold their value after Done until the next accepted Start. They are not cleared on IDLE entry.
- Start while Busy (RUN or DONE): ignored, no queueing. Operand changes during RUN are ignored.
- Back-to-back: the earliest next accept is the cycle after DONE, giving 66-cycle throughput.
- Reset mid-RUN: abort immediately, all outputs to reset values, no write request issued.
- The register file writes on the falling edge. RegWrReq/Result are stable from the rising edge that starts DONE, so the write lands mid-cycle of DONE.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MUL, OP_UMULH, OP_SMULH.
  - State encoding: IDLE/RUN/DONE.
  - DATA_W and XZR index (31), shared with the register file and control unit.
- No sub-module is required.
- Optional helper mul_sign_fix (combinational abs/negate) if reused by a future divider.

Test Plan:
- MUL 3×5, Rd=2, Start cycle 0 → Done=1 and RegWrReq=1 only in cycle 65, Result=0x000000000000000F, ResultRd=2, Busy high cycles 1..65.
- OpA=0xFFFFFFFFFFFFFFFF, OpB=2:
  - MUL → Result=0xFFFFFFFFFFFFFFFE.
  - UMULH → Result=0x0000000000000001.
- SMULH cases:
  - -1 × 1 → Result=0xFFFFFFFFFFFFFFFF.
  - 0x8000000000000000 × 0x8000000000000000 → Result=0x4000000000000000.
  - 7 × -3 → Result=0xFFFFFFFFFFFFFFFF.
- Start pulsed with new operands in cycle 10 during RUN → ignored; first result unchanged, exactly one Done pulse in cycle 65.
- Reset asserted asynchronously mid-cycle 30 → Busy/Done/RegWrReq/Result drop to 0 immediately. A new MUL 6×7 started after reset release yields Result=0x2A 65 cycles later.
- MUL 4×4 with Rd=31 → Done=1 in cycle 65, RegWrReq=0, Result=0x10.
